// File: rtl/freq_to_ftw.sv
// freq_to_ftw: tuning frequency (Hz) to NCO FTW by restoring division; define FTW_ROUND_EN for round-to-nearest
module freq_to_ftw #(
  parameter int unsigned CLK_HZ   = 61440000,
  parameter int unsigned MAX_FREQ = 30720000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] freq_in,
  input  logic        freq_valid,
  output logic [31:0] ftw_out,
  output logic        ftw_valid,
  output logic        busy,
  output logic        range_err
);
`ifdef FTW_ROUND_EN
  localparam int QW = 33;
`else
  localparam int QW = 32;
`endif
  localparam logic [5:0] LAST = 6'(QW - 1);
  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] req_reg, pend_reg, rem, rem_nx, ftw_nx;
  logic [32:0] r2;
  logic [QW-1:0] quo, quo_nx;
  logic [5:0] cnt;
  logic pend, over, rel, take, ge;
  always_comb begin
    over = req_reg > MAX_FREQ;
    rel = state == IDLE || state == DONE || (state == CHECK && over);
    take = rel && (freq_valid || pend);
    r2 = {rem, 1'b0};
    ge = r2 >= 33'(CLK_HZ);
    rem_nx = ge ? 32'(r2 - 33'(CLK_HZ)) : r2[31:0];
    quo_nx = {quo[QW-2:0], ge};
`ifdef FTW_ROUND_EN
    ftw_nx = quo_nx[32:1] + 32'(quo_nx[0]);
`else
    ftw_nx = quo_nx;
`endif
    state_nx = take ? CHECK : rel ? IDLE : state == CHECK ? DIV :
               (state == DIV && cnt == LAST) ? DONE : state;
    range_err = state == CHECK && over;
    ftw_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      ftw_out <= '0;
      req_reg <= '0;
      pend_reg <= '0;
      pend <= 1'b0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      busy <= state_nx != IDLE;
      // a strobe coinciding with a release point wins over an older pending value
      if (take) begin
        req_reg <= freq_valid ? freq_in : pend_reg;
        pend <= 1'b0;
      end else if (freq_valid) begin
        pend_reg <= freq_in;
        pend <= 1'b1;
      end
      if (state == CHECK) begin
        rem <= req_reg;
        quo <= '0;
        cnt <= '0;
      end
      if (state == DIV) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 6'd1;
        if (cnt == LAST) ftw_out <= ftw_nx;
      end
    end
  end
endmodule

// File: tb/tb_freq_to_ftw.sv
// tb_freq_to_ftw: scoreboard bench for freq_to_ftw, expectations follow FTW_ROUND_EN
module tb_freq_to_ftw;
`ifdef FTW_ROUND_EN
  localparam int LAT = 35;
  localparam logic [31:0] F1M = 32'd69905067;
`else
  localparam int LAT = 34;
  localparam logic [31:0] F1M = 32'd69905066;
`endif
  localparam logic [31:0] F2M = 32'd139810133;
  localparam logic [31:0] F71 = 32'd496325973;
  localparam logic [31:0] FNY = 32'd2147483648;
  typedef struct {logic err; logic [31:0] ftw; int cyc;} exp_t;
  exp_t sb[$];
  logic clk = 0, rst_n = 0, freq_valid = 0;
  logic [31:0] freq_in = '0;
  logic [31:0] ftw_out;
  logic ftw_valid, busy, range_err;
  int cyc = 0, checks = 0, errors = 0;
  freq_to_ftw dut (.clk(clk), .rst_n(rst_n), .freq_in(freq_in), .freq_valid(freq_valid),
                   .ftw_out(ftw_out), .ftw_valid(ftw_valid), .busy(busy), .range_err(range_err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic err, input logic [31:0] ftw, input int c);
    exp_t e;
    e.err = err;
    e.ftw = ftw;
    e.cyc = c;
    sb.push_back(e);
  endtask
  task automatic strobe(input logic [31:0] v);
    freq_in = v;
    freq_valid = 1;
    tick(1);
    freq_valid = 0;
  endtask
  task automatic conv(input logic [31:0] v, input logic [31:0] e);
    push(0, e, cyc + LAT);
    strobe(v);
    chk("busy_rise", busy, 1);
    tick(LAT);
    chk("busy_fall", busy, 0);
    chk("ftw_hold", ftw_out, e);
  endtask
  always @(negedge clk) begin
    if (rst_n && (ftw_valid || range_err)) begin
      if (sb.size() == 0) chk("unexpected_output", {ftw_valid, range_err}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_kind_err", range_err, e.err);
        chk("out_kind_valid", ftw_valid, !e.err);
        chk("out_cycle", cyc, e.cyc);
        if (!e.err) chk("ftw_value", ftw_out, e.ftw);
      end
    end
  end
  initial begin
    int n;
    tick(3);
    chk("rst_ftw", ftw_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ftw_valid, 0);
    chk("rst_err", range_err, 0);
    rst_n = 1;
    tick(1);
    conv(32'd1000000, F1M);
    conv(32'd0, 32'd0);
    conv(32'd30720000, FNY);
    n = cyc;
    push(1, 0, n + 1);
    strobe(32'd30720001);
    tick(1);
    chk("rej_busy", busy, 0);
    chk("rej_ftw_hold", ftw_out, FNY);
    push(1, 0, cyc + 1);
    strobe(32'hFFFF_FFFF);
    tick(1);
    chk("rej_max_busy", busy, 0);
    n = cyc;
    push(1, 0, n + 1);
    push(0, F1M, n + 1 + LAT);
    strobe(32'd40000000);
    strobe(32'd1000000);
    tick(LAT);
    chk("rej_pend_idle", busy, 0);
    n = cyc;
    push(0, F71, n + LAT);
    push(0, F2M, n + 2 * LAT);
    strobe(32'd7100000);
    tick(4);
    strobe(32'd1000000);
    tick(4);
    strobe(32'd2000000);
    tick(2 * LAT + 1 - 11);
    chk("pend_idle", busy, 0);
    chk("pend_ftw", ftw_out, F2M);
    n = cyc;
    strobe(32'd7100000);
    tick(19);
    rst_n = 0;
    tick(1);
    chk("midrst_ftw", ftw_out, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1;
    tick(LAT + 5);
    chk("midrst_quiet_busy", busy, 0);
    conv(32'd1000000, F1M);
    n = cyc;
    push(0, F71, n + LAT);
    push(0, F1M, n + 2 * LAT);
    strobe(32'd7100000);
    tick(LAT - 1);
    chk("b2b_done", ftw_valid, 1);
    strobe(32'd1000000);
    chk("b2b_busy", busy, 1);
    tick(LAT);
    chk("b2b_idle", busy, 0);
    chk("b2b_ftw", ftw_out, F1M);
    tick(5);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
